// File: rtl/seq_detector_moore_param.sv
// seq_detector_moore_param
// Moore sequence detector for a strobed stream of SYM_W-bit symbols. Matches a
// fixed SEQ_LEN-symbol PATTERN (first symbol in the MSBs), with overlapping or
// non-overlapping detection. yout is registered and reflects the last accepted
// symbol.
// Optional feature macro: SEQDET_COUNT_EN. When it is defined, the match_count
// port and its CNT_W-bit saturating counter are compiled in.
module seq_detector_moore_param #(
    parameter int                         SYM_W   = 2,
    parameter int                         SEQ_LEN = 4,
    parameter logic [SYM_W*SEQ_LEN-1:0]   PATTERN = 8'b00_11_00_10,
    parameter bit                         OVERLAP = 1'b1,
    parameter int                         CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SYM_W-1:0]   ain,
    input  logic               ain_valid,
    input  logic               clear,
    output logic               yout
`ifdef SEQDET_COUNT_EN
    ,
    output logic [CNT_W-1:0]   match_count
`endif
);

    localparam int               FILL_W    = $clog2(SEQ_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(SEQ_LEN);
    localparam logic [FILL_W-1:0] FILL_QUAL = FILL_W'(SEQ_LEN - 1);

    // Elaboration-time sanity checks on the configuration.
    if (SYM_W < 1) begin : g_bad_sym_w
        $error("seq_detector_moore_param: SYM_W must be >= 1");
    end
    if (SEQ_LEN < 2 || SEQ_LEN > 16) begin : g_bad_seq_len
        $error("seq_detector_moore_param: SEQ_LEN must be 2..16");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("seq_detector_moore_param: CNT_W must be >= 1");
    end

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MATCH = 1'b1
    } state_t;

    // Only the newest SEQ_LEN-1 symbols are stored. Together with the incoming
    // symbol they form the full SEQ_LEN-symbol window. The oldest window symbol
    // would never be read again, so it is not kept.
    logic [SEQ_LEN-2:0][SYM_W-1:0] hist_q, hist_d;
    logic [SEQ_LEN-1:0][SYM_W-1:0] window;
    logic [FILL_W-1:0]             fill_q, fill_d;
    state_t                        state_q, state_d;

    logic [SEQ_LEN-1:0]            sym_eq;
    logic                          accept;
    logic                          qualified;
    logic                          hit;

    assign window    = {hist_q, ain};
    assign accept    = ain_valid && !clear;
    assign qualified = (fill_q >= FILL_QUAL);

    // Per-symbol comparators. window[0] is the newest symbol and lines up with
    // the last pattern symbol in the LSBs.
    for (genvar i = 0; i < SEQ_LEN; i++) begin : g_cmp
        assign sym_eq[i] = (window[i] == PATTERN[i*SYM_W +: SYM_W]);
    end

    // The fill qualifier prevents a zeroed history from matching an all-zero
    // pattern straight after reset or clear.
    assign hit = accept && qualified && (&sym_eq);

    // State register: history, fill level and match state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hist_q  <= '0;
            fill_q  <= '0;
            state_q <= ST_IDLE;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            state_q <= state_d;
        end
    end

    // Next state. clear wins over accept, and a non-accepting cycle holds everything.
    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        state_d = state_q;
        if (clear) begin
            hist_d  = '0;
            fill_d  = '0;
            state_d = ST_IDLE;
        end else if (accept) begin
            hist_d  = window[SEQ_LEN-2:0];
            fill_d  = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 1'b1;
            state_d = hit ? ST_MATCH : ST_IDLE;
            if (hit && !OVERLAP) begin
                // Non-overlapping mode: the next match must be built from fresh symbols.
                fill_d = '0;
            end
        end
    end

    // Moore output, decoded from the state register only.
    assign yout = (state_q == ST_MATCH);

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating match counter. It steps on the same edge that raises yout.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign match_count = cnt_q;
`endif

endmodule

// File: doc/seq_detector_moore_param.md
# seq_detector_moore_param

Parametrised Moore-type sequence detector for the lab digital-design library. It is the generalised successor of the fixed 2-bit-symbol detector. It matches a compile-time pattern of `SEQ_LEN` symbols, each `SYM_W` bits wide, on a strobed symbol stream, with selectable overlapping or non-overlapping detection. It also keeps an optional saturating match counter, and sits between a symbol source (switch debouncer or test stimulus) and LED/status logic.

## Interface
Parameters:
- `SYM_W`, 2: symbol width in bits (≥1).
- `SEQ_LEN`, 4: pattern length in symbols (2..16).
- `PATTERN`, 8'b00_11_00_10: `SYM_W*SEQ_LEN` bits. The first symbol is in the MSBs; the default is 00, 11, 00, 10.
- `OVERLAP`, 1: 1 means overlapping detection; 0 means history is cleared after each match.
- `CNT_W`, 8: match counter width.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: synchronous, active-low reset.
- `ain`, input, `SYM_W`: input symbol.
- `ain_valid`, input, 1: `ain` is accepted on a rising edge only when this is 1.
- `clear`, input, 1: synchronous soft clear of history, `yout` and counter. It is active-high and has lower priority than `reset`.
- `yout`, output, 1: Moore match output, registered.
- `match_count`, output, `CNT_W`: saturating match count. Present only with `SEQDET_COUNT_EN`.

## Operation
- State:
  - History shift register `hist` of `SEQ_LEN` symbols.
  - Fill counter `fill` in 0..`SEQ_LEN`, saturating.
  - Match state bit that drives `yout`.
- Accept: on an edge with `reset`=1, `clear`=0 and `ain_valid`=1:
  - `ain` shifts into the LSB end of `hist`.
  - `fill` increments, saturating at `SEQ_LEN`.
- Match condition, evaluated on accept:
  - The condition is `fill` ≥ `SEQ_LEN`-1 before the shift, and the shifted history equals `PATTERN`.
  - On a match, `yout` is set to 1. On an accept without a match, `yout` is set to 0.
- `OVERLAP`=1: history and `fill` are retained after a match, so the pattern suffix can seed the next match.
- `OVERLAP`=0: on a match, `fill` is set to 0, so the next match needs `SEQ_LEN` fresh symbols.
- No accept (`ain_valid`=0): all state holds, including `yout`. `yout` therefore reflects the last accepted symbol (Moore behaviour).
- `clear`=1 (with `reset`=1):
  - `hist`, `fill`, `yout` and `match_count` are set to 0.
  - The `ain` presented on that edge is ignored.
- Priority: `reset` > `clear` > accept.

## Timing
- Reset values: `yout`=0 and `match_count`=0; internally `hist`=0 and `fill`=0.
- A history of zeros never matches until `fill` qualifies, so a pattern of all zeros does not false-fire after reset.
- Latency: `yout` rises on the same rising edge that accepts the final pattern symbol, so it is visible one cycle after `ain` is presented.
- With `ain_valid` held at 1 and no re-match, `yout` is a one-cycle pulse.
- Back-to-back overlapping matches keep `yout` at 1 on consecutive cycles; each match is counted separately.
- Reset or clear during a partial match discards all progress; the next match needs `SEQ_LEN` accepted symbols.
- `match_count` increments on the same edge that sets `yout` for a match. It saturates at 2^`CNT_W`-1 and never wraps.
- No combinational path exists from any input to any output.

## Configuration
- Macro `SEQDET_COUNT_EN`.
- When defined: the `match_count` port and its `CNT_W`-bit saturating counter are compiled in.
- When undefined: the port and counter are absent, and `CNT_W` is ignored. Detection behaviour is identical either way.

## Test plan
- Defaults, `reset`=0 for 2 cycles, then `ain_valid`=1 with stream 00, 11, 00, 10, 00 on successive cycles:
  - `yout`=1 for exactly the one cycle after the 10 is accepted.
  - `match_count`=1.
- Defaults, same stream with `ain_valid`=0 inserted for 3 cycles between 11 and 00:
  - The match is still detected.
  - `yout`=1 from the edge accepting 10 until the next accepted symbol, even if `ain_valid` then stays 0.
- `SYM_W`=1, `SEQ_LEN`=3, `PATTERN`=3'b101, stream 1, 0, 1, 0, 1:
  - With `OVERLAP`=1: 2 matches, `yout` high after the 3rd and 5th symbols, `match_count`=2.
  - With `OVERLAP`=0: 1 match, after the 3rd symbol only.
- Defaults, stream 00, 11, 00, then `reset`=0 for one cycle, then 10:
  - No match; `yout` stays 0.
  - Repeat with `clear`=1 instead of `reset`: same result.
- Defaults, `CNT_W`=2, 5 complete patterns:
  - `match_count` reads 1, 2, 3, 3, 3 (saturates).
  - `yout` pulses 5 times.
- Build without `SEQDET_COUNT_EN` and rerun scenario 1:
  - Identical `yout` waveform.
  - No `match_count` port.
